alu: RTL and testbench
======================

# alu

Registered 32-bit arithmetic/logic unit for the Phase 1 datapath. It computes one of thirteen operations on two operands, selected by a 4-bit opcode. Results are captured on the rising clock edge, one cycle after the operands and opcode are presented. Multiply and divide also produce a high/remainder word for the HI/LO-style Z register.

## Interface
- `DATA_WIDTH`, default 32: operand and result width. Only 32 is required and verified.
- `clk` input, 1 bit: single clock. All state updates on the rising edge.
- `reset` input, 1 bit: reset is synchronous and active-high.
- `input_a` input, DATA_WIDTH bits: operand A.
- `input_b` input, DATA_WIDTH bits: operand B. For shifts and rotates it is the shift amount.
- `opcode` input, 4 bits: operation select.
- `alu_result` output, DATA_WIDTH bits, registered: primary result (low word, or quotient).
- `alu_result_hi` output, DATA_WIDTH bits, registered: high product word or remainder. Zero for all other ops.

## Operation
Opcode map:
- 0 OR: A | B
- 1 AND: A & B
- 2 NOT: ~A (B ignored)
- 3 ADD: A + B, mod 2^32. Carry discarded.
- 4 SUB: A − B, mod 2^32.
- 5 NEG: two's complement −A, i.e. ~A + 1.
- 6 MUL: signed 32×32 → 64. Low word goes to `alu_result`, high word to `alu_result_hi`.
- 7 DIV: signed division, truncating toward zero. Quotient goes to `alu_result`, remainder (sign of A) to `alu_result_hi`.
- 8 SHL: logical left shift of A by B[4:0]. Zeros fill from the right.
- 9 SHR: logical right shift of A by B[4:0]. Zeros fill from the left.
- 10 SHRA: arithmetic right shift of A by B[4:0]. A[31] fills from the left.
- 11 ROL: rotate A left by B[4:0].
- 12 ROR: rotate A right by B[4:0].
- 13–15: reserved. Both outputs load 0.

Rules:
- Shift amount uses B[4:0] only. B[31:5] is ignored.
- A shift or rotate amount of 0 returns A unchanged.
- Divide by zero (B = 0): quotient 0xFFFFFFFF, remainder = A. No error flag.
- Overflow case 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
- `alu_result_hi` = 0 for every opcode other than 6 and 7.
- The output registers have no enable and hold no other state.

## Timing
- Latency is 1 cycle. Operands and opcode sampled at edge N appear on the outputs after edge N and hold until edge N+1.
- Throughput is one operation per cycle. No handshake.
- MUL and DIV also complete in one cycle, so the combinational path must close timing at the target clock. No multi-cycle divider.
- Reset value of both outputs is 0x00000000.
- If `reset` is high at an edge, both outputs load 0 regardless of opcode. Reset has priority.
- On the first edge after `reset` deasserts, the current inputs are computed normally.
- An opcode change mid-stream takes effect on the next edge. There is no pipeline hazard.

## Test plan
- Reset: hold `reset` for 2 cycles with A = 20, B = 5, opcode = 3 → both outputs 0. One edge after release → `alu_result` = 25.
- Logic and arithmetic, A = 20, B = 5:
  - OR → 21; AND → 4
  - NOT → 0xFFFFFFEB; NEG → 0xFFFFFFEC
  - ADD → 25; SUB → 15
  - `alu_result_hi` = 0 for all of these.
- Mul/div:
  - A = 20, B = 5, MUL → lo 100, hi 0.
  - A = −7, B = 3, MUL → lo 0xFFFFFFEB, hi 0xFFFFFFFF.
  - A = 20, B = 5, DIV → 4 rem 0.
  - A = −7, B = 2, DIV → 0xFFFFFFFD rem 0xFFFFFFFF.
  - A = 9, B = 0, DIV → 0xFFFFFFFF rem 9.
- Shifts and rotates, A = 0x000000B2, B = 2:
  - SHL → 0x000002C8; SHR → 0x0000002C
  - ROL → 0x000002C8; ROR → 0x8000002C
  - With A = 0x80000000, B = 4: SHRA → 0xF8000000
  - With B = 0x22 (only B[4:0] = 2 used): SHL → 0x000002C8
- Edges: ADD 0xFFFFFFFF + 1 → 0. ROL by 0 → A. Opcode 14 → both outputs 0.
- Back-to-back: change opcode every cycle across ops 0–12 → each result appears exactly one edge after its inputs, with no stale or skipped values.

Source files
------------

// File: rtl/alu_if.sv
// Operand/result bundle between the datapath and the registered ALU.
// No handshake: one operation per cycle, results valid one edge after operands.
interface alu_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] input_a;
  logic [DATA_WIDTH-1:0] input_b;
  logic [3:0]            opcode;
  logic [DATA_WIDTH-1:0] alu_result;
  logic [DATA_WIDTH-1:0] alu_result_hi;

  modport master (
    output input_a, input_b, opcode,
    input  alu_result, alu_result_hi
  );

  modport slave (
    input  input_a, input_b, opcode,
    output alu_result, alu_result_hi
  );
endinterface

// File: rtl/alu.sv
// Registered 13-op ALU with HI word for MUL/DIV; 1-cycle latency, one op per cycle.
// No backpressure: inputs are sampled on every edge and the outputs always reload.
module alu #(
  parameter int DATA_WIDTH = 32
) (
  input logic  clk,
  input logic  reset,
  alu_if.slave bus
);
  localparam int SW = $clog2(DATA_WIDTH);

  typedef enum logic [3:0] {
    OP_OR   = 4'd0,
    OP_AND  = 4'd1,
    OP_NOT  = 4'd2,
    OP_ADD  = 4'd3,
    OP_SUB  = 4'd4,
    OP_NEG  = 4'd5,
    OP_MUL  = 4'd6,
    OP_DIV  = 4'd7,
    OP_SHL  = 4'd8,
    OP_SHR  = 4'd9,
    OP_SHRA = 4'd10,
    OP_ROL  = 4'd11,
    OP_ROR  = 4'd12
  } op_t;

  logic [DATA_WIDTH-1:0]          a;
  logic [DATA_WIDTH-1:0]          b;
  logic [SW-1:0]                  shamt;
  logic signed [2*DATA_WIDTH-1:0] product;
  logic [2*DATA_WIDTH-1:0]        rol_dbl;
  logic [2*DATA_WIDTH-1:0]        ror_dbl;
  logic signed [DATA_WIDTH-1:0]   sra;
  logic signed [DATA_WIDTH-1:0]   quot;
  logic signed [DATA_WIDTH-1:0]   rem;
  logic                           div_zero;
  logic                           div_ovf;
  logic [DATA_WIDTH-1:0]          res_lo;
  logic [DATA_WIDTH-1:0]          res_hi;

  assign a     = bus.input_a;
  assign b     = bus.input_b;
  assign shamt = b[SW-1:0];

  assign product = $signed({{DATA_WIDTH{a[DATA_WIDTH-1]}}, a}) *
                   $signed({{DATA_WIDTH{b[DATA_WIDTH-1]}}, b});

  // Rotates shift a doubled copy so the wrapped bits land in the kept half.
  assign rol_dbl = {a, a} << shamt;
  assign ror_dbl = {a, a} >> shamt;
  assign sra     = $signed(a) >>> shamt;

  // Zero divisor and MIN/-1 are steered away from the divider so its result is never used there.
  assign div_zero = (b == '0);
  assign div_ovf  = (a == {1'b1, {(DATA_WIDTH-1){1'b0}}}) && (b == '1);

  always_comb begin
    quot = '0;
    rem  = '0;
    if (!div_zero && !div_ovf) begin
      quot = $signed(a) / $signed(b);
      rem  = $signed(a) % $signed(b);
    end
  end

  always_comb begin
    res_lo = '0;
    res_hi = '0;
    case (op_t'(bus.opcode))
      OP_OR:   res_lo = a | b;
      OP_AND:  res_lo = a & b;
      OP_NOT:  res_lo = ~a;
      OP_ADD:  res_lo = a + b;
      OP_SUB:  res_lo = a - b;
      OP_NEG:  res_lo = ~a + 1'b1;
      OP_MUL: begin
        res_lo = product[DATA_WIDTH-1:0];
        res_hi = product[2*DATA_WIDTH-1:DATA_WIDTH];
      end
      OP_DIV: begin
        if (div_zero) begin
          res_lo = '1;
          res_hi = a;
        end else if (div_ovf) begin
          res_lo = a;
          res_hi = '0;
        end else begin
          res_lo = quot;
          res_hi = rem;
        end
      end
      OP_SHL:  res_lo = a << shamt;
      OP_SHR:  res_lo = a >> shamt;
      OP_SHRA: res_lo = sra;
      OP_ROL:  res_lo = rol_dbl[2*DATA_WIDTH-1:DATA_WIDTH];
      OP_ROR:  res_lo = ror_dbl[DATA_WIDTH-1:0];
      default: begin
        res_lo = '0;
        res_hi = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.alu_result    <= '0;
      bus.alu_result_hi <= '0;
    end else begin
      bus.alu_result    <= res_lo;
      bus.alu_result_hi <= res_hi;
    end
  end
endmodule

// File: tb/tb_alu.sv
// Directed and back-to-back checks of the registered ALU against an independent bit-level model.
module tb_alu;
  logic clk;
  logic reset;

  alu_if #(.DATA_WIDTH(32)) bus ();

  alu #(.DATA_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model written bitwise / with 64-bit arithmetic, independent of the RTL structure.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                       output logic [31:0] lo, output logic [31:0] hi);
    longint p;
    int     s;
    lo = 32'h0;
    hi = 32'h0;
    s  = int'(b[4:0]);
    case (op)
      4'd0: lo = a | b;
      4'd1: lo = a & b;
      4'd2: lo = a ^ 32'hFFFF_FFFF;
      4'd3: lo = 32'(longint'(a) + longint'(b));
      4'd4: lo = 32'(longint'(a) - longint'(b));
      4'd5: lo = 32'(64'd0 - longint'(a));
      4'd6: begin
        p  = longint'($signed(a)) * longint'($signed(b));
        lo = p[31:0];
        hi = p[63:32];
      end
      4'd7: begin
        if (b == 32'h0) begin
          lo = 32'hFFFF_FFFF;
          hi = a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          lo = 32'h8000_0000;
          hi = 32'h0;
        end else begin
          p  = longint'($signed(a)) / longint'($signed(b));
          lo = p[31:0];
          p  = longint'($signed(a)) - p * longint'($signed(b));
          hi = p[31:0];
        end
      end
      4'd8:  for (int i = 0; i < 32; i++) lo[i] = (i >= s) ? a[i-s] : 1'b0;
      4'd9:  for (int i = 0; i < 32; i++) lo[i] = (i + s < 32) ? a[i+s] : 1'b0;
      4'd10: for (int i = 0; i < 32; i++) lo[i] = (i + s < 32) ? a[i+s] : a[31];
      4'd11: for (int i = 0; i < 32; i++) lo[(i+s)%32] = a[i];
      4'd12: for (int i = 0; i < 32; i++) lo[i] = a[(i+s)%32];
      default: begin
        lo = 32'h0;
        hi = 32'h0;
      end
    endcase
  endtask

  task automatic check_out();
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed lo=%h hi=%h required an expected entry",
             bus.alu_result, bus.alu_result_hi);
    end else begin
      e = sb.pop_front();
      assert ({bus.alu_result, bus.alu_result_hi} === {e.lo, e.hi}) else begin
        n_fail++;
        $error("FAIL %s: observed lo=%h hi=%h expected lo=%h hi=%h",
               e.tag, bus.alu_result, bus.alu_result_hi, e.lo, e.hi);
      end
    end
  endtask

  // Drive one cycle of inputs, push the expectation, and compare one edge later.
  task automatic step(input logic r, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] op, input logic [31:0] lo, input logic [31:0] hi,
                      input string tag);
    exp_t e;
    reset       = r;
    bus.input_a = a;
    bus.input_b = b;
    bus.opcode  = op;
    e.lo  = lo;
    e.hi  = hi;
    e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic step_model(input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] op, input string tag);
    logic [31:0] lo;
    logic [31:0] hi;
    model(a, b, op, lo, hi);
    step(1'b0, a, b, op, lo, hi, tag);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;

    step(1'b1, 32'd20, 32'd5, 4'd3, 32'h0, 32'h0, "reset_cycle1");
    step(1'b1, 32'd20, 32'd5, 4'd3, 32'h0, 32'h0, "reset_cycle2");
    step(1'b0, 32'd20, 32'd5, 4'd3, 32'd25, 32'h0, "first_after_reset_add");

    step(1'b0, 32'd20, 32'd5, 4'd0, 32'd21, 32'h0, "or");
    step(1'b0, 32'd20, 32'd5, 4'd1, 32'd4, 32'h0, "and");
    step(1'b0, 32'd20, 32'd5, 4'd2, 32'hFFFF_FFEB, 32'h0, "not");
    step(1'b0, 32'd20, 32'd5, 4'd5, 32'hFFFF_FFEC, 32'h0, "neg");
    step(1'b0, 32'd20, 32'd5, 4'd3, 32'd25, 32'h0, "add");
    step(1'b0, 32'd20, 32'd5, 4'd4, 32'd15, 32'h0, "sub");

    step(1'b0, 32'd20, 32'd5, 4'd6, 32'd100, 32'h0, "mul_pos");
    step(1'b0, 32'hFFFF_FFF9, 32'd3, 4'd6, 32'hFFFF_FFEB, 32'hFFFF_FFFF, "mul_neg");
    step(1'b0, 32'd20, 32'd5, 4'd7, 32'd4, 32'h0, "div_pos");
    step(1'b0, 32'hFFFF_FFF9, 32'd2, 4'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, "div_neg");
    step(1'b0, 32'd9, 32'd0, 4'd7, 32'hFFFF_FFFF, 32'd9, "div_by_zero");
    step(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 4'd7, 32'h8000_0000, 32'h0, "div_overflow");

    step(1'b0, 32'h0000_00B2, 32'd2, 4'd8, 32'h0000_02C8, 32'h0, "shl");
    step(1'b0, 32'h0000_00B2, 32'd2, 4'd9, 32'h0000_002C, 32'h0, "shr");
    step(1'b0, 32'h0000_00B2, 32'd2, 4'd11, 32'h0000_02C8, 32'h0, "rol");
    step(1'b0, 32'h0000_00B2, 32'd2, 4'd12, 32'h8000_002C, 32'h0, "ror");
    step(1'b0, 32'h8000_0000, 32'd4, 4'd10, 32'hF800_0000, 32'h0, "shra");
    step(1'b0, 32'h0000_00B2, 32'h22, 4'd8, 32'h0000_02C8, 32'h0, "shl_b_upper_ignored");

    step(1'b0, 32'hFFFF_FFFF, 32'd1, 4'd3, 32'h0, 32'h0, "add_wrap");
    step(1'b0, 32'h1234_5678, 32'd0, 4'd11, 32'h1234_5678, 32'h0, "rol_by_zero");
    step(1'b0, 32'd20, 32'd5, 4'd14, 32'h0, 32'h0, "reserved_14");
    step(1'b0, 32'd20, 32'd5, 4'd15, 32'h0, 32'h0, "reserved_15");
    step(1'b1, 32'hFFFF_FFF9, 32'd3, 4'd6, 32'h0, 32'h0, "reset_priority_mul");

    for (int round = 0; round < 3; round++) begin
      for (int op = 0; op <= 12; op++) begin
        ra = $urandom;
        rb = (round == 2) ? ($urandom_range(0, 40)) : $urandom;
        step_model(ra, rb, 4'(op), $sformatf("b2b_r%0d_op%0d", round, op));
      end
    end

    if (sb.size() != 0) begin
      n_fail++;
      $error("FAIL scoreboard_leftover: observed %0d entries required 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
